// File: rtl/dac_spi_receiver_if.sv
// Serial frame, decoded-field and register read-back signals of the DAC SPI receiver.
// The master side drives the serial line and read address; the slave side is the receiver.
interface dac_spi_receiver_if;
   logic        sdi;
   logic        cs;
   logic        frame_valid;
   logic [3:0]  cmd;
   logic [3:0]  addr;
   logic [15:0] value;
   logic        frame_error;
   logic        cmd_error;
   logic [7:0]  update_mask;
   logic [2:0]  rd_addr;
   logic [15:0] rd_input;
   logic [15:0] rd_dac;

   modport master (
      output sdi, cs, rd_addr,
      input  frame_valid, cmd, addr, value, frame_error, cmd_error, update_mask,
      input  rd_input, rd_dac
   );

   modport slave (
      input  sdi, cs, rd_addr,
      output frame_valid, cmd, addr, value, frame_error, cmd_error, update_mask,
      output rd_input, rd_dac
   );
endinterface

// File: rtl/dac_spi_receiver.sv
// 24-bit SPI command receiver driving 8 double-buffered DAC channels (input + DAC registers).
// Frames are {cmd[3:0], addr[3:0], value[15:0]}, MSB first, framed by active-low cs.
module dac_spi_receiver #(
   parameter logic [15:0] RESET_CODE = 16'h0000
) (
   input logic               clk25,
   input logic               reset,
   dac_spi_receiver_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StShift, StOverrun} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [23:0] shift_q, shift_d;
   logic        accept_q, accept_d;
   logic        frame_err_d;

   logic        frame_valid_q, frame_error_q, cmd_error_q;
   logic [7:0]  update_mask_q;
   logic [3:0]  cmd_q, addr_q;
   logic [15:0] value_q;
   logic [15:0] rd_input_q, rd_dac_q;

   logic [15:0] in_reg_q  [8];
   logic [15:0] in_reg_d  [8];
   logic [15:0] dac_reg_q [8];
   logic [15:0] dac_reg_d [8];

   logic [3:0]  f_cmd, f_addr;
   logic [15:0] f_val;
   logic [7:0]  sel;
   logic        addr_ok;
   logic        cmd_err_d;
   logic [7:0]  mask_d;

   // Serial framing: a full frame parks in StShift with cnt=24 until cs rises or a 25th bit lands.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      accept_d    = 1'b0;
      frame_err_d = 1'b0;
      if (bus.cs) begin
         cnt_d   = '0;
         state_d = StIdle;
         if (state_q == StShift && cnt_q != 5'd0 && cnt_q < 5'd24) frame_err_d = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               shift_d = {shift_q[22:0], bus.sdi};
               cnt_d   = 5'd1;
               state_d = StShift;
            end
            StShift: begin
               if (cnt_q == 5'd24) begin
                  state_d     = StOverrun;
                  frame_err_d = 1'b1;
               end else begin
                  shift_d  = {shift_q[22:0], bus.sdi};
                  cnt_d    = cnt_q + 5'd1;
                  accept_d = (cnt_q == 5'd23);
               end
            end
            StOverrun: state_d = StOverrun;
            default:   state_d = StIdle;
         endcase
      end
   end

   assign f_cmd   = shift_q[23:20];
   assign f_addr  = shift_q[19:16];
   assign f_val   = shift_q[15:0];
   assign addr_ok = (f_addr == 4'hF) || !f_addr[3];

   always_comb begin
      sel = '0;
      if (f_addr == 4'hF)  sel = '1;
      else if (!f_addr[3]) sel = 8'd1 << f_addr[2:0];
   end

   // Command execution; shift_q still holds the completed frame during the accept cycle.
   always_comb begin
      in_reg_d  = in_reg_q;
      dac_reg_d = dac_reg_q;
      mask_d    = '0;
      cmd_err_d = 1'b0;
      if (accept_q) begin
         if (f_cmd == 4'd4) begin
            for (int n = 0; n < 8; n++) begin
               in_reg_d[n]  = RESET_CODE;
               dac_reg_d[n] = RESET_CODE;
            end
            mask_d = '1;
         end else if (f_cmd[3:2] != 2'b00 || !addr_ok) begin
            cmd_err_d = 1'b1;
         end else begin
            for (int n = 0; n < 8; n++) begin
               if (sel[n]) begin
                  case (f_cmd[1:0])
                     2'd0: in_reg_d[n]  = f_val;
                     2'd1: dac_reg_d[n] = in_reg_q[n];
                     2'd2: in_reg_d[n]  = f_val;
                     2'd3: begin
                        in_reg_d[n]  = f_val;
                        dac_reg_d[n] = f_val;
                     end
                  endcase
               end
            end
            // cmd 2 transfers every channel, picking up the value just written.
            if (f_cmd[1:0] == 2'd2) begin
               for (int n = 0; n < 8; n++) dac_reg_d[n] = in_reg_d[n];
               mask_d = '1;
            end else if (f_cmd[0]) begin
               mask_d = sel;
            end
         end
      end
   end

   always_ff @(posedge clk25) begin
      if (reset) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         shift_q       <= '0;
         accept_q      <= 1'b0;
         frame_valid_q <= 1'b0;
         frame_error_q <= 1'b0;
         cmd_error_q   <= 1'b0;
         update_mask_q <= '0;
         cmd_q         <= '0;
         addr_q        <= '0;
         value_q       <= '0;
         rd_input_q    <= RESET_CODE;
         rd_dac_q      <= RESET_CODE;
         for (int n = 0; n < 8; n++) begin
            in_reg_q[n]  <= RESET_CODE;
            dac_reg_q[n] <= RESET_CODE;
         end
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         shift_q       <= shift_d;
         accept_q      <= accept_d;
         frame_valid_q <= accept_q;
         frame_error_q <= frame_err_d;
         cmd_error_q   <= cmd_err_d;
         update_mask_q <= mask_d;
         if (accept_q) begin
            cmd_q   <= f_cmd;
            addr_q  <= f_addr;
            value_q <= f_val;
         end
         rd_input_q <= in_reg_q[bus.rd_addr];
         rd_dac_q   <= dac_reg_q[bus.rd_addr];
         in_reg_q   <= in_reg_d;
         dac_reg_q  <= dac_reg_d;
      end
   end

   assign bus.frame_valid = frame_valid_q;
   assign bus.frame_error = frame_error_q;
   assign bus.cmd_error   = cmd_error_q;
   assign bus.update_mask = update_mask_q;
   assign bus.cmd         = cmd_q;
   assign bus.addr        = addr_q;
   assign bus.value       = value_q;
   assign bus.rd_input    = rd_input_q;
   assign bus.rd_dac      = rd_dac_q;

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Directed bench for dac_spi_receiver: framing, command semantics, error pulses and reset.
module tb_dac_spi_receiver;
   localparam logic [15:0] RC = 16'h1357;

   logic clk25 = 1'b0;
   logic reset = 1'b1;

   dac_spi_receiver_if sif ();

   dac_spi_receiver #(.RESET_CODE(RC)) dut (
      .clk25 (clk25),
      .reset (reset),
      .bus   (sif)
   );

   always #5 clk25 = ~clk25;

   int checks   = 0;
   int failures = 0;

   int         fv_cnt, fe_cnt, ce_cnt, fv_at;
   logic [7:0] mask_acc;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic sample(input int idx);
      @(posedge clk25);
      #1;
      if (sif.frame_valid) begin
         fv_cnt++;
         fv_at = idx;
      end
      if (sif.frame_error) fe_cnt++;
      if (sif.cmd_error) ce_cnt++;
      mask_acc = mask_acc | sif.update_mask;
   endtask

   // Sends nbits with cs low (bits past 24 are 1s), then tail cycles with cs high.
   task automatic send(input logic [23:0] f, input int nbits, input int tail);
      fv_cnt   = 0;
      fe_cnt   = 0;
      ce_cnt   = 0;
      fv_at    = -1;
      mask_acc = '0;
      for (int i = 0; i < nbits + tail; i++) begin
         @(negedge clk25);
         if (i < nbits) begin
            sif.cs  = 1'b0;
            sif.sdi = (i < 24) ? f[23-i] : 1'b1;
         end else begin
            sif.cs  = 1'b1;
            sif.sdi = 1'b0;
         end
         sample(i);
      end
   endtask

   task automatic check_ch(input string tag, input logic [2:0] ch, input logic [15:0] exp_in,
                           input logic [15:0] exp_dac);
      @(negedge clk25);
      sif.rd_addr = ch;
      @(posedge clk25);
      #1;
      check_eq($sformatf("%s_in%0d", tag, ch), {16'h0, sif.rd_input}, {16'h0, exp_in});
      check_eq($sformatf("%s_dac%0d", tag, ch), {16'h0, sif.rd_dac}, {16'h0, exp_dac});
   endtask

   task automatic check_pulses(input string tag, input int fv, input int fe, input int ce,
                               input logic [7:0] mask);
      check_eq({tag, "_fv"}, fv_cnt, fv);
      check_eq({tag, "_fe"}, fe_cnt, fe);
      check_eq({tag, "_ce"}, ce_cnt, ce);
      check_eq({tag, "_mask"}, {24'h0, mask_acc}, {24'h0, mask});
   endtask

   task automatic check_fields(input string tag, input logic [3:0] c, input logic [3:0] a,
                               input logic [15:0] v);
      check_eq({tag, "_cmd"}, {28'h0, sif.cmd}, {28'h0, c});
      check_eq({tag, "_addr"}, {28'h0, sif.addr}, {28'h0, a});
      check_eq({tag, "_value"}, {16'h0, sif.value}, {16'h0, v});
   endtask

   initial begin
      sif.cs      = 1'b1;
      sif.sdi     = 1'b0;
      sif.rd_addr = 3'd0;
      repeat (3) @(posedge clk25);
      #1;
      check_eq("rst_fv", {31'h0, sif.frame_valid}, 32'h0);
      check_eq("rst_fe", {31'h0, sif.frame_error}, 32'h0);
      check_eq("rst_ce", {31'h0, sif.cmd_error}, 32'h0);
      check_eq("rst_mask", {24'h0, sif.update_mask}, 32'h0);
      check_fields("rst", 4'h0, 4'h0, 16'h0);
      check_eq("rst_rd_in", {16'h0, sif.rd_input}, {16'h0, RC});
      check_eq("rst_rd_dac", {16'h0, sif.rd_dac}, {16'h0, RC});
      @(negedge clk25);
      reset = 1'b0;

      // cmd 3 write-through to channel 2
      send(24'h32ABCD, 24, 2);
      check_pulses("f326", 1, 0, 0, 8'h04);
      check_eq("f326_fv_at", fv_at, 24);
      check_fields("f326", 4'h3, 4'h2, 16'hABCD);
      check_ch("f326", 3'd2, 16'hABCD, 16'hABCD);
      check_ch("f326", 3'd1, RC, RC);

      // back-to-back frames, cs high for a single cycle
      send(24'h051234, 24, 1);
      check_pulses("f051", 1, 0, 0, 8'h00);
      check_eq("f051_fv_at", fv_at, 24);
      check_fields("f051", 4'h0, 4'h5, 16'h1234);
      send(24'h150000, 24, 2);
      check_pulses("f150", 1, 0, 0, 8'h20);
      check_ch("f150", 3'd5, 16'h1234, 16'h1234);

      // short frame
      send(24'hFFFFFF, 12, 3);
      check_pulses("short", 0, 1, 0, 8'h00);
      check_fields("short", 4'h1, 4'h5, 16'h0000);
      check_ch("short", 3'd5, 16'h1234, 16'h1234);

      // long frame: 24 good bits plus 6 extra
      send(24'h015555, 30, 3);
      check_pulses("long", 1, 1, 0, 8'h00);
      check_eq("long_fv_at", fv_at, 24);
      check_fields("long", 4'h0, 4'h1, 16'h5555);
      check_ch("long", 3'd1, 16'h5555, RC);

      // broadcast cmd 2, then unsupported cmd and addr
      send(24'h2F7777, 24, 2);
      check_pulses("f2f", 1, 0, 0, 8'hFF);
      check_ch("f2f", 3'd0, 16'h7777, 16'h7777);
      check_ch("f2f", 3'd7, 16'h7777, 16'h7777);
      send(24'h700000, 24, 2);
      check_pulses("f700", 1, 0, 1, 8'h00);
      check_fields("f700", 4'h7, 4'h0, 16'h0000);
      check_ch("f700", 3'd0, 16'h7777, 16'h7777);
      send(24'h090000, 24, 2);
      check_pulses("f090", 1, 0, 1, 8'h00);
      check_ch("f090", 3'd1, 16'h7777, 16'h7777);

      // soft reset ignores addr
      send(24'h431111, 24, 2);
      check_pulses("f4", 1, 0, 0, 8'hFF);
      check_ch("f4", 3'd2, RC, RC);

      // cmd 3 broadcast, then cmd 2 must use the freshly written input
      send(24'h3F0042, 24, 2);
      check_pulses("f3f", 1, 0, 0, 8'hFF);
      send(24'h040099, 24, 2);
      check_pulses("f04", 1, 0, 0, 8'h00);
      send(24'h260011, 24, 2);
      check_pulses("f26", 1, 0, 0, 8'hFF);
      check_ch("f26", 3'd4, 16'h0099, 16'h0099);
      check_ch("f26", 3'd6, 16'h0011, 16'h0011);
      check_ch("f26", 3'd0, 16'h0042, 16'h0042);

      // reset mid-frame
      fe_cnt = 0;
      fv_cnt = 0;
      ce_cnt = 0;
      mask_acc = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk25);
         sif.cs  = 1'b0;
         sif.sdi = 1'b1;
         sample(i);
      end
      @(negedge clk25);
      reset = 1'b1;
      sample(10);
      sample(11);
      @(negedge clk25);
      reset  = 1'b0;
      sif.cs = 1'b1;
      sample(12);
      sample(13);
      check_eq("mid_rst_fe", fe_cnt, 0);
      check_eq("mid_rst_fv", fv_cnt, 0);
      check_ch("mid_rst", 3'd0, RC, RC);
      check_ch("mid_rst", 3'd6, RC, RC);
      send(24'h0000FF, 24, 2);
      check_pulses("post_rst", 1, 0, 0, 8'h00);
      check_ch("post_rst", 3'd0, 16'h00FF, RC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
